reg_bank_2r1w: RTL and testbench
================================

// Module: reg_bank_2r1w
// PURPOSE
//  Parametrised register bank: the successor to the single 32-bit CE register.
//  Holds DEPTH words of WIDTH bits, with one byte-enabled write port and two
//  independently enabled, registered read ports.
//  Serves as the CPU general-purpose register file and the peripheral
//  register bank in the microcomputer datapath.
// PARAMETERS
//  WIDTH     32  data word width in bits; must be a multiple of 8
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is a normal register
// PORTS
//  clk      in   1         rising-edge clock
//  rst      in   1         synchronous reset, active-low
//  we       in   1         write enable
//  waddr    in   ADDR_W    write address
//  wdata    in   WIDTH     write data
//  wbe      in   WIDTH/8   byte enables; bit i covers wdata[8i+7:8i]
//  re_a     in   1         read-port A enable
//  raddr_a  in   ADDR_W    read-port A address
//  rdata_a  out  WIDTH     read-port A data, registered
//  re_b     in   1         read-port B enable
//  raddr_b  in   ADDR_W    read-port B address
//  rdata_b  out  WIDTH     read-port B data, registered
// BEHAVIOUR
//  - Reset: rst==0 at a clk edge clears every entry, rdata_a and rdata_b to 0.
//    Reset overrides we, re_a and re_b on that edge. There is no async path.
//  - Write: on an edge with rst==1 and we==1, entry[waddr] byte i <= wdata byte i
//    for each wbe[i]==1. Bytes with wbe[i]==0 keep their value.
//    we==1 with wbe==0 is a legal no-op.
//  - ZERO_REG==1: writes to waddr==0 are dropped, and reads of address 0 return 0.
//  - Read: on an edge with rst==1 and re_x==1, rdata_x <= entry[raddr_x].
//    Latency is 1 clock from address to data.
//    re_x==0 holds rdata_x at its previous value, like the CE register.
//  - Ports A and B are fully independent. Both may read the same address in the
//    same cycle and receive identical data.
//  - Read/write collision (same edge, re_x==1, raddr_x==waddr, we==1):
//    governed by BYPASS_EN (see CONFIGURATION). The array write always completes.
//  - Out-of-range addresses cannot occur because DEPTH is 2**ADDR_W.
//  - Reset asserted mid-sequence discards all pending writes and reads of that edge.
//  - X on wdata with we==0 or wbe==0 must not corrupt any entry.
// CONFIGURATION
//  BYPASS_EN defined:
//    On a collision, rdata_x <= merged word: the new bytes where wbe==1,
//    the old entry bytes elsewhere.
//    ZERO_REG still forces address 0 to read 0.
//  BYPASS_EN undefined:
//    On a collision, rdata_x <= the old entry contents (read-before-write).
//    The new value is visible from the next read onward.
// TESTING
//  1. Reset: write 0xDEADBEEF to r5, pulse rst=0 for 1 clk, read r5 on A
//     -> rdata_a=0 and rdata_b=0 after reset.
//  2. Byte enables: write r3=0x11223344 (wbe=F), then wdata=0xAABBCCDD with wbe=0101b
//     -> read r3 = 0x11BB33DD.
//  3. Zero register (ZERO_REG=1): write r0=0xFFFFFFFF, read r0 on A and B
//     -> both 0; with ZERO_REG=0 -> 0xFFFFFFFF.
//  4. Hold: read r7=0x12345678 on A, drop re_a, write r7=0x0 and change raddr_a
//     -> rdata_a stays 0x12345678.
//  5. Collision: r9=0x0, same edge we=1 wdata=0x000000FF wbe=1 and re_a=1 raddr_a=9
//     -> rdata_a=0x000000FF with BYPASS_EN, 0x00000000 without it.
//     The next read returns 0xFF in both builds.
//  6. Dual port: A reads r1=0x1, B reads r2=0x2 on the same edge
//     -> rdata_a=0x1 and rdata_b=0x2, one cycle later.

Source files
------------

// File: rtl/reg_bank_2r1w.sv
// DEPTH x WIDTH register bank with one byte-enabled write port and two registered read ports.
// Optional macro BYPASS_EN: a read colliding with a write returns the freshly merged word.
module reg_bank_2r1w #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [WIDTH/8-1:0]   wbe,
   input  logic                 re_a,
   input  logic [ADDR_W-1:0]    raddr_a,
   output logic [WIDTH-1:0]     rdata_a,
   input  logic                 re_b,
   input  logic [ADDR_W-1:0]    raddr_b,
   output logic [WIDTH-1:0]     rdata_b
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int NBYTES = WIDTH / 8;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] rd_a_next;
   logic [WIDTH-1:0] rd_b_next;
   logic             wr_en;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_mask
         assign wmask[8*gi +: 8] = {8{wbe[gi]}};
      end
   endgenerate

   // Masking both terms keeps undriven data bytes from reaching the array.
   assign merged = (mem_reg[waddr] & ~wmask) | (wdata & wmask);
   assign wr_en  = we && !((ZERO_REG != 0) && (waddr == '0));

   always_comb begin
      rd_a_next = mem_reg[raddr_a];
`ifdef BYPASS_EN
      if (we && (raddr_a == waddr))
         rd_a_next = merged;
`endif
      if ((ZERO_REG != 0) && (raddr_a == '0))
         rd_a_next = '0;
   end

   always_comb begin
      rd_b_next = mem_reg[raddr_b];
`ifdef BYPASS_EN
      if (we && (raddr_b == waddr))
         rd_b_next = merged;
`endif
      if ((ZERO_REG != 0) && (raddr_b == '0))
         rd_b_next = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (wr_en)
            mem_reg[waddr] <= merged;
         if (re_a)
            rdata_a <= rd_a_next;
         if (re_b)
            rdata_b <= rd_b_next;
      end
   end

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Directed table-driven bench for reg_bank_2r1w; a second instance with ZERO_REG=0 shares the stimulus.
// Collision expectations follow the BYPASS_EN macro.
module tb_reg_bank_2r1w;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic        re_a;
   logic [4:0]  raddr_a;
   logic        re_b;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_a, rdata_b;
   logic [31:0] rdata_a_nz, rdata_b_nz;

   int checks = 0;
   int failures = 0;

`ifdef BYPASS_EN
   localparam logic [31:0] COLL_A = 32'h0000_00FF;
   localparam logic [31:0] COLL_B = 32'hAABB_3344;
`else
   localparam logic [31:0] COLL_A = 32'h0000_0000;
   localparam logic [31:0] COLL_B = 32'hAABB_CCDD;
`endif

   reg_bank_2r1w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
   );

   reg_bank_2r1w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_nz),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_nz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wbe;
      logic        re_a;
      logic [4:0]  raddr_a;
      logic        re_b;
      logic [4:0]  raddr_b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic ra_en, input logic [4:0] ra,
                               input logic rb_en, input logic [4:0] rb,
                               input logic [31:0] ea, input logic [31:0] eb);
      vec_t v;
      v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.wbe = be;
      v.re_a = ra_en; v.raddr_a = ra; v.re_b = rb_en; v.raddr_b = rb;
      v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic ra_en, input logic [4:0] ra,
                        input logic rb_en, input logic [4:0] rb);
      rst = r; we = w; waddr = wa; wdata = wd; wbe = be;
      re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      //             rst we wa  wdata          wbe    rea ra  reb rb   exp_a          exp_b
      vecs.push_back(mk(0, 0, 0, 32'h0,         4'h0, 0, 0,  0, 0,  32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF,  4'hF, 0, 0,  0, 0,  32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 5,  0, 0,  32'hDEADBEEF,  32'h0));
      vecs.push_back(mk(0, 1, 5, 32'h12345678,  4'hF, 1, 5,  1, 5,  32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 5,  1, 5,  32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 3, 32'h11223344,  4'hF, 0, 0,  0, 0,  32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 3, 32'hAABBCCDD,  4'h5, 0, 0,  0, 0,  32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 3,  1, 3,  32'h11BB33DD,  32'h11BB33DD));
      vecs.push_back(mk(1, 1, 1, 32'h1,         4'hF, 0, 3,  0, 3,  32'h11BB33DD,  32'h11BB33DD));
      vecs.push_back(mk(1, 1, 2, 32'h2,         4'hF, 0, 0,  0, 0,  32'h11BB33DD,  32'h11BB33DD));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 1,  1, 2,  32'h1,         32'h2));
      vecs.push_back(mk(1, 1, 1, 32'hxxxxxxxx,  4'h0, 0, 0,  0, 0,  32'h1,         32'h2));
      vecs.push_back(mk(1, 0, 2, 32'hxxxxxxxx,  4'hF, 0, 0,  0, 0,  32'h1,         32'h2));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 1,  1, 2,  32'h1,         32'h2));
      vecs.push_back(mk(1, 1, 9, 32'h0,         4'hF, 0, 0,  0, 0,  32'h1,         32'h2));
      vecs.push_back(mk(1, 1, 9, 32'h000000FF,  4'h1, 1, 9,  0, 0,  COLL_A,        32'h2));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 9,  0, 0,  32'hFF,        32'h2));
      vecs.push_back(mk(1, 1, 10, 32'hAABBCCDD, 4'hF, 0, 0,  0, 0,  32'hFF,        32'h2));
      vecs.push_back(mk(1, 1, 10, 32'h11223344, 4'h3, 0, 0,  1, 10, 32'hFF,        COLL_B));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 0, 0,  1, 10, 32'hFF,        32'hAABB3344));
      vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF,  4'hF, 1, 0,  1, 0,  32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         4'h0, 1, 0,  1, 0,  32'h0,         32'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wbe,
               vecs[i].re_a, vecs[i].raddr_a, vecs[i].re_b, vecs[i].raddr_b);
         check($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
         check($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
      end

      // Same stimulus without the hardwired zero: r0 keeps what was written.
      check("nz_r0_a", rdata_a_nz, 32'hFFFFFFFF);
      check("nz_r0_b", rdata_b_nz, 32'hFFFFFFFF);

      // Hold: a disabled read port keeps its word across writes and address changes.
      drive(1, 1, 7, 32'h12345678, 4'hF, 0, 0, 0, 0);
      drive(1, 0, 0, 32'h0,        4'h0, 1, 7, 0, 0);
      check("hold_load", rdata_a, 32'h12345678);
      drive(1, 1, 7, 32'h0,        4'hF, 0, 3, 0, 0);
      check("hold_1", rdata_a, 32'h12345678);
      drive(1, 0, 0, 32'h0,        4'h0, 0, 9, 0, 0);
      check("hold_2", rdata_a, 32'h12345678);
      drive(1, 0, 0, 32'h0,        4'h0, 1, 7, 0, 0);
      check("hold_new", rdata_a, 32'h0);

      // Reset in the middle of traffic wins over the write and both reads.
      drive(1, 0, 0, 32'h0,        4'h0, 1, 3, 1, 9);
      check("pre_rst_a", rdata_a, 32'h11BB33DD);
      check("pre_rst_b", rdata_b, 32'hFF);
      drive(0, 1, 7, 32'hABCDABCD, 4'hF, 1, 3, 1, 9);
      check("mid_rst_a", rdata_a, 32'h0);
      check("mid_rst_b", rdata_b, 32'h0);
      drive(1, 0, 0, 32'h0,        4'h0, 1, 3, 1, 7);
      check("post_rst_a", rdata_a, 32'h0);
      check("post_rst_b", rdata_b, 32'h0);
      check("post_rst_nz_a", rdata_a_nz, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
